int_div_int_to_fixed_point: RTL
===============================

// Module: int_div_int_to_fixed_point
// PURPOSE
//  Multi-cycle signed divider: integer / integer -> fixed point as {fixed_X integer part, fixed_Y = 5-digit decimal fraction}.
//  Produces the fixed-point operands consumed by the int*fixed and int/fixed units (ray step ratios, distance scaling).
//  Restoring binary division: integer quotient first, then fraction = (remainder*SCALE)/|den|.
//  start/ready/done handshake; one operation in flight.
// PARAMETERS
//  IN_W       21      width of signed num/den
//  X_W        10      width of signed fixed_X
//  Y_W        18      width of signed fixed_Y
//  SCALE      100000  fraction scale (5 d.p.)
//  FRAC_BITS  17      fraction quotient bits; must satisfy 2**FRAC_BITS > SCALE
// PORTS
//  clk       in   1     clock, rising edge
//  reset     in   1     asynchronous, active-high reset
//  start     in   1     request; sampled only while ready=1
//  num       in   IN_W  signed numerator, latched when start accepted
//  den       in   IN_W  signed denominator, latched when start accepted
//  ready     out  1     1 in IDLE only
//  done      out  1     one-cycle pulse, result valid
//  fixed_X   out  X_W   signed integer part of quotient
//  fixed_Y   out  Y_W   signed fraction digits, 0..SCALE-1 magnitude
//  ovf       out  1     integer part saturated (valid with done, held)
//  div0      out  1     den was zero (valid with done, held)
// BEHAVIOUR
//  Reset: state=IDLE, ready=1, done=0, fixed_X=0, fixed_Y=0, ovf=0, div0=0; async, any state.
//  States: IDLE -> INT (IN_W cycles) -> FRAC (FRAC_BITS cycles) -> FIN (1 cycle) -> IDLE.
//  IDLE: start=1 latches |num|, |den|, sign=num[MSB]^den[MSB], div0 flag; go INT.
//  INT: one restoring step/cycle; q_int=|num|/|den|, rem=|num|%|den| (truncation).
//  FRAC: one step/cycle on rem*SCALE (IN_W-1+FRAC_BITS bits wide); q_frac=(rem*SCALE)/|den|.
//  FIN: apply sign + saturation, register outputs, done=1 in the following cycle, ready=1 again.
//  Latency constant: done high exactly IN_W+FRAC_BITS+1 = 39 edges after the accepting edge, incl. div0.
//  Sign: both parts carry the quotient sign; -1.5 -> X=-1, Y=-50000; -0.5 -> X=0, Y=-50000. Zero -> Y=0, never -0.
//  Saturation: q_int > 2**(X_W-1)-1 -> X=+/-511, Y=+/-99999, ovf=1.
//  den=0: X=+511, Y=+99999, div0=1, ovf=0, regardless of num sign (num=0 included).
//  start while not ready: ignored, no effect on in-flight op or latched operands.
//  Back-to-back: start in the done cycle is accepted (ready=1 there).
//  Outputs hold last result until next done; done never asserted twice per op.
//  num=-2**(IN_W-1) handled: magnitude computed in IN_W bits unsigned.
//  Reset mid-operation: abort, outputs to reset values, no done.
// CONFIGURATION
//  FIXED_DIV_ROUND_EN defined: fraction rounded half-up on magnitude: q_frac=(rem*SCALE+(|den|>>1))/|den|;
//   if q_frac==SCALE then Y=0, q_int+=1, saturation rechecked after carry. Latency unchanged.
//  Not defined: fraction truncated toward zero. Default: not defined.
// TESTING
//  3/2 start at edge E -> done at E+39, X=1, Y=50000, ovf=0, div0=0; ready=0 from E+1 to E+38.
//  2/3 -> X=0, Y=66666 (66667 with FIXED_DIV_ROUND_EN); -7/3 -> X=-2, Y=-33333 both builds.
//  399999/200000 -> X=1, Y=99999; with FIXED_DIV_ROUND_EN X=2, Y=0.
//  1000000/3 -> X=511, Y=99999, ovf=1; -1000000/3 -> X=-511, Y=-99999, ovf=1.
//  5/0 and -5/0 -> X=511, Y=99999, div0=1, done at +39; next op 1/4 -> Y=25000, div0=0.
//  start pulsed at +5 and +20 while busy -> ignored; reset at +20 -> all outputs 0, ready=1, no done.

Source files
------------

// File: rtl/int_div_int_to_fixed_point.sv
// rtl/int_div_int_to_fixed_point.sv - multi-cycle signed integer/integer divider producing {integer, 5-digit decimal fraction}
//
// Purpose : restoring binary divider. The integer quotient |num|/|den| is formed
//           first (IN_W steps), then the fraction (rem*SCALE)/|den| (FRAC_BITS
//           steps), then one finishing cycle applies sign and saturation.
// Ports   : clk      in   clock, rising edge
//           reset    in   asynchronous active-high reset
//           start    in   request, sampled only while ready=1
//           num/den  in   signed operands, latched when start is accepted
//           ready    out  1 while idle
//           done     out  one-cycle pulse, result valid
//           fixed_X  out  signed integer part of quotient
//           fixed_Y  out  signed fraction digits (magnitude 0..SCALE-1)
//           ovf      out  integer part saturated (held with result)
//           div0     out  denominator was zero (held with result)
// Config  : FIXED_DIV_ROUND_EN - round the fraction half-up instead of truncating.
module int_div_int_to_fixed_point #(
    parameter int IN_W      = 21,
    parameter int X_W       = 10,
    parameter int Y_W       = 18,
    parameter int SCALE     = 100000,
    parameter int FRAC_BITS = 17
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic signed [IN_W-1:0] num,
    input  logic signed [IN_W-1:0] den,
    output logic                   ready,
    output logic                   done,
    output logic signed [X_W-1:0]  fixed_X,
    output logic signed [Y_W-1:0]  fixed_Y,
    output logic                   ovf,
    output logic                   div0
);

    localparam int PROD_W = IN_W - 1 + FRAC_BITS;
    localparam int CNT_W  = $clog2(IN_W + 1);
    localparam int X_MAX  = 2 ** (X_W - 1) - 1;

    typedef enum logic [1:0] {S_IDLE, S_INT, S_FRAC, S_FIN} state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [IN_W-1:0]      r_den;
    logic [IN_W-1:0]      r_rem;
    logic [IN_W-1:0]      r_quo;
    logic [FRAC_BITS-1:0] r_qf;
    logic                 r_sign;
    logic                 r_div0;

    // Operand magnitudes; the most negative input maps to 2**(IN_W-1) unsigned.
    logic [IN_W-1:0] w_num_abs;
    logic [IN_W-1:0] w_den_abs;
    assign w_num_abs = num[IN_W-1] ? $unsigned(-num) : $unsigned(num);
    assign w_den_abs = den[IN_W-1] ? $unsigned(-den) : $unsigned(den);

    // One restoring step shared by both phases; only the dividend source differs.
    logic            w_in_bit;
    logic [IN_W:0]   w_shift;
    logic            w_ge;
    logic [IN_W-1:0] w_diff;
    logic [IN_W-1:0] w_rem_step;
    assign w_in_bit   = (r_state == S_INT) ? r_quo[IN_W-1] : r_qf[FRAC_BITS-1];
    assign w_shift    = {r_rem, w_in_bit};
    assign w_ge       = w_shift >= {1'b0, r_den};
    // When w_ge holds the true difference is below r_den, so the low IN_W bits suffice.
    assign w_diff     = w_shift[IN_W-1:0] - r_den;
    assign w_rem_step = w_ge ? w_diff : w_shift[IN_W-1:0];

    // Fraction dividend. Its quotient is below 2**FRAC_BITS, so the top bits are
    // already smaller than |den| and can seed the partial remainder directly,
    // leaving only FRAC_BITS steps to run.
    logic [PROD_W-1:0] w_prod;
`ifdef FIXED_DIV_ROUND_EN
    assign w_prod = PROD_W'(w_rem_step) * PROD_W'(SCALE) + PROD_W'(r_den >> 1);
`else
    assign w_prod = PROD_W'(w_rem_step) * PROD_W'(SCALE);
`endif

    logic w_last_int;
    logic w_last_frac;
    assign w_last_int  = (r_cnt == CNT_W'(IN_W - 1));
    assign w_last_frac = (r_cnt == CNT_W'(FRAC_BITS - 1));

    // Finishing: optional rounding carry, saturation, then sign.
    logic [IN_W:0]          w_qi;
    logic [FRAC_BITS-1:0]   w_qf;
    logic                   w_sat;
    logic [X_W-1:0]         w_mag_x;
    logic [Y_W-1:0]         w_mag_y;
    logic signed [X_W-1:0]  w_res_x;
    logic signed [Y_W-1:0]  w_res_y;

    always_comb begin
        w_qi = {1'b0, r_quo};
        w_qf = r_qf;
`ifdef FIXED_DIV_ROUND_EN
        if (r_qf == FRAC_BITS'(SCALE)) begin
            w_qi = {1'b0, r_quo} + (IN_W+1)'(1);
            w_qf = '0;
        end
`endif
        w_sat   = w_qi > (IN_W+1)'(X_MAX);
        w_mag_x = w_sat ? X_W'(X_MAX) : w_qi[X_W-1:0];
        w_mag_y = w_sat ? Y_W'(SCALE - 1) : Y_W'(w_qf);
        if (r_div0) begin
            w_res_x = X_W'(X_MAX);
            w_res_y = Y_W'(SCALE - 1);
        end else if (r_sign) begin
            // Negating zero yields zero, so no negative-zero case exists.
            w_res_x = -$signed(w_mag_x);
            w_res_y = -$signed(w_mag_y);
        end else begin
            w_res_x = $signed(w_mag_x);
            w_res_y = $signed(w_mag_y);
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next state and ready.
    always_comb begin
        w_state_nxt = r_state;
        ready       = 1'b0;
        case (r_state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) w_state_nxt = S_INT;
            end
            S_INT:   if (w_last_int)  w_state_nxt = S_FRAC;
            S_FRAC:  if (w_last_frac) w_state_nxt = S_FIN;
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath and result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_den   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_qf    <= '0;
            r_sign  <= 1'b0;
            r_div0  <= 1'b0;
            done    <= 1'b0;
            fixed_X <= '0;
            fixed_Y <= '0;
            ovf     <= 1'b0;
            div0    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_rem  <= '0;
                        r_quo  <= w_num_abs;
                        r_den  <= w_den_abs;
                        r_sign <= num[IN_W-1] ^ den[IN_W-1];
                        r_div0 <= (den == '0);
                        r_cnt  <= '0;
                    end
                end
                S_INT: begin
                    r_quo <= {r_quo[IN_W-2:0], w_ge};
                    if (w_last_int) begin
                        r_rem <= {1'b0, w_prod[PROD_W-1:FRAC_BITS]};
                        r_qf  <= w_prod[FRAC_BITS-1:0];
                        r_cnt <= '0;
                    end else begin
                        r_rem <= w_rem_step;
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_FRAC: begin
                    r_rem <= w_rem_step;
                    r_qf  <= {r_qf[FRAC_BITS-2:0], w_ge};
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                S_FIN: begin
                    fixed_X <= w_res_x;
                    fixed_Y <= w_res_y;
                    ovf     <= r_div0 ? 1'b0 : w_sat;
                    div0    <= r_div0;
                    done    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
